fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch sequencer that consumes the `Jump` and `BranchEn` decodes from the control decoder, together with the ALU zero flag. It drives the instruction-ROM address and runs a start/done handshake with the testbench or top level. Jump and branch targets come from an internal, writable target lookup table. The table is indexed by instruction bits above the 3-bit opcode.

## Interface
- `PW`, 10: program counter width; instruction ROM depth is 2^PW.
- `LAW`, 4: target-LUT address width; the LUT has 2^LAW entries of PW bits.
- `CW`, 16: retired-instruction counter width.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  start request, level-sampled.
- `StartAddr`  in  PW  first PC value of a run.
- `Jump`  in  1  unconditional jump decode from the control decoder.
- `BranchEn`  in  1  branch decode from the control decoder.
- `Zero`  in  1  ALU zero flag; a branch is taken when `BranchEn & Zero`.
- `Halt`  in  1  halt-instruction decode.
- `TgtIdx`  in  LAW  LUT index, i.e. instruction bits [LAW+2:3].
- `LutWe`  in  1  LUT write enable.
- `LutAddr`  in  LAW  LUT write address.
- `LutData`  in  PW  LUT write data.
- `PC`  out  PW  instruction-ROM address.
- `Fetch`  out  1  PC is valid and the instruction at PC executes this cycle.
- `Done`  out  1  program has halted.
- `Retired`  out  CW  instructions executed in the current run, saturating.

## Operation
- **States:** IDLE, RUN, DONE.
- **Reset values:** state=IDLE, `PC`=0, `Fetch`=0, `Done`=0, `Retired`=0, all LUT entries 0.
- **IDLE:**
  - `Start`=1 → RUN, `PC`←`StartAddr`, `Retired`←0.
  - `LutWe`=1 writes `LUT[LutAddr]`←`LutData`.
- **RUN** (`Fetch`=1): each cycle one instruction executes. Next PC is chosen by priority:
  1. `Halt` → DONE; `PC` holds (it keeps the halt address).
  2. `Jump` → `PC`←`LUT[TgtIdx]`, an absolute target.
  3. `BranchEn & Zero` → `PC`←`PC` + sign-extended `LUT[TgtIdx]` (entry read as signed PW-bit), modulo 2^PW.
  4. otherwise `PC`←`PC`+1, modulo 2^PW (wraps 2^PW−1 → 0).
- `BranchEn` with `Zero`=0 is not taken and gives `PC`+1.
- `Jump` and `BranchEn` both high: `Jump` wins.
- Every RUN cycle, including the halt cycle, increments `Retired`; it saturates at 2^CW−1.
- `LutWe` in RUN is ignored: the LUT is frozen while running. `Start` in RUN is ignored.
- **DONE:**
  - `Done`=1 and `Fetch`=0; `PC` and `Retired` hold.
  - `Start`=1 → RUN with `PC`←`StartAddr`, `Retired`←0, and `Done` falls on the same edge.
  - `LutWe` is honoured.
- `Jump`, `BranchEn`, `Zero`, `Halt` and `TgtIdx` are ignored outside RUN.
- `Reset_n` low at any time, mid-run included: all state returns to reset values immediately (asynchronously), and LUT contents are cleared.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- **Start latency:** `Start` sampled high at edge N → at N+1 `PC`=`StartAddr`, `Fetch`=1.
- **Same-cycle decode:** during a RUN cycle the ROM output and the decoder/ALU signals for the current `PC` settle combinationally. The next-PC choice is registered at the following edge, so a taken jump/branch has zero bubble cycles.
- **Halt latency:** `Halt` high in the cycle at edge M → at M+1 `Done`=1, `Fetch`=0.
- **LUT timing:** a write at edge K is visible to a lookup from K+1 on. The LUT read is combinational from `TgtIdx`.
- **Reset release:** state is IDLE on the first edge after `Reset_n` rises; `Start` is sampled on that edge.

## Test plan
- **Reset:** drive `Reset_n`=0 → all outputs 0, state IDLE. Assert reset mid-RUN at `PC`=37 → `PC`=0, `Fetch`=0 with no clock edge needed.
- **Sequential run with wrap:** `StartAddr`=1021, PW=10, no jumps → `PC` goes 1021, 1022, 1023, 0, 1. Then `Halt` at `PC`=1 → `Done`=1, `PC`=1, `Retired`=5.
- **Jump:** in IDLE write `LUT[3]`=200; run from 0 with `Jump`=1, `TgtIdx`=3 at `PC`=2 → the next `PC` is 200. Then a same-cycle `Jump`+`BranchEn`+`Zero` → the LUT absolute target is taken.
- **Branch:** `LUT[5]`=10'h3FC (−4). At `PC`=50, `BranchEn`=1: with `Zero`=1 → `PC`=46; with `Zero`=0 → `PC`=51. At `PC`=2 with offset −4 → `PC`=1022.
- **Handshake and LUT freeze:** `LutWe` pulses during RUN leave the LUT unchanged. `Start` during RUN leaves `PC` unaffected. `Start` in DONE with `StartAddr`=7 → RUN, `PC`=7, `Retired`=0, `Done`=0 after one edge.
- **Counter saturation:** with CW=4, run 20 instructions → `Retired` stops at 15.

Source files
------------

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE handshake, absolute jumps and
// PC-relative branches resolved through a writable target LUT, saturating retire count.
module fetch_unit #(
  parameter int unsigned PW  = 10,
  parameter int unsigned LAW = 4,
  parameter int unsigned CW  = 16
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic [PW-1:0]  StartAddr,
  input  logic           Jump,
  input  logic           BranchEn,
  input  logic           Zero,
  input  logic           Halt,
  input  logic [LAW-1:0] TgtIdx,
  input  logic           LutWe,
  input  logic [LAW-1:0] LutAddr,
  input  logic [PW-1:0]  LutData,
  output logic [PW-1:0]  PC,
  output logic           Fetch,
  output logic           Done,
  output logic [CW-1:0]  Retired
);

  localparam int unsigned LutDepth = 2 ** LAW;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic            fetch_q, fetch_d;
  logic            done_q, done_d;
  logic [CW-1:0]   retired_q, retired_d;
  logic [PW-1:0]   lut_q [LutDepth];
  logic            lut_we;
  logic [PW-1:0]   tgt;

  assign tgt = lut_q[TgtIdx];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    fetch_d   = fetch_q;
    done_d    = done_q;
    retired_d = retired_q;
    lut_we    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        lut_we = LutWe;
        if (Start) begin
          state_d   = StRun;
          pc_d      = StartAddr;
          retired_d = '0;
          fetch_d   = 1'b1;
          done_d    = 1'b0;
        end
      end
      StRun: begin
        if (!(&retired_q)) retired_d = retired_q + {{(CW-1){1'b0}}, 1'b1};
        if (Halt) begin
          state_d = StDone;
          fetch_d = 1'b0;
          done_d  = 1'b1;
        end else if (Jump) begin
          pc_d = tgt;
        end else if (BranchEn && Zero) begin
          // Two's-complement add modulo 2^PW is the signed offset.
          pc_d = pc_q + tgt;
        end else begin
          pc_d = pc_q + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      fetch_q   <= 1'b0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fetch_q   <= fetch_d;
      done_q    <= done_d;
      retired_q <= retired_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < LutDepth; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[LutAddr] <= LutData;
    end
  end

  assign PC      = pc_q;
  assign Fetch   = fetch_q;
  assign Done    = done_q;
  assign Retired = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default-width instance plus a CW=4 instance for
// retire-counter saturation, both driven from the same stimulus.
module tb_fetch_unit;

  logic       clk, reset_n, start, jump, branch_en, zero, halt, lut_we;
  logic [9:0] start_addr, lut_data;
  logic [3:0] tgt_idx, lut_addr;
  logic [9:0] pc, sat_pc;
  logic       fetch, done, sat_fetch, sat_done;
  logic [15:0] retired;
  logic [3:0]  sat_retired;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.PW(10), .LAW(4), .CW(16)) u_dut (
    .Clk(clk), .Reset_n(reset_n), .Start(start), .StartAddr(start_addr), .Jump(jump),
    .BranchEn(branch_en), .Zero(zero), .Halt(halt), .TgtIdx(tgt_idx), .LutWe(lut_we),
    .LutAddr(lut_addr), .LutData(lut_data), .PC(pc), .Fetch(fetch), .Done(done),
    .Retired(retired)
  );

  fetch_unit #(.PW(10), .LAW(4), .CW(4)) u_sat (
    .Clk(clk), .Reset_n(reset_n), .Start(start), .StartAddr(start_addr), .Jump(jump),
    .BranchEn(branch_en), .Zero(zero), .Halt(halt), .TgtIdx(tgt_idx), .LutWe(lut_we),
    .LutAddr(lut_addr), .LutData(lut_data), .PC(sat_pc), .Fetch(sat_fetch),
    .Done(sat_done), .Retired(sat_retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_decodes();
    jump = 0; branch_en = 0; zero = 0; halt = 0; tgt_idx = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic write_lut(input logic [3:0] a, input logic [9:0] d);
    lut_we = 1; lut_addr = a; lut_data = d;
    tick();
    lut_we = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_vec++;
    if ({pc, fetch, done, retired} !== 28'd0) begin
      n_err++;
      $display("FAIL reset_outputs: pc=%0d fetch=%b done=%b retired=%0d, want all 0",
               pc, fetch, done, retired);
    end
    reset_n = 1'b1;
    tick();
    tick();
    n_vec++;
    if (fetch !== 1'b0 || pc !== 10'd0) begin
      n_err++;
      $display("FAIL reset_idle_hold: fetch=%b pc=%0d, want 0 0", fetch, pc);
    end
  endtask

  task automatic test_seq_wrap();
    logic [9:0] exp_pc [5];
    exp_pc[0] = 1021; exp_pc[1] = 1022; exp_pc[2] = 1023; exp_pc[3] = 0; exp_pc[4] = 1;
    start_addr = 10'd1021; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (pc !== exp_pc[i] || fetch !== 1'b1 || retired !== 16'(i)) begin
        n_err++;
        $display("FAIL seq_wrap[%0d]: pc=%0d fetch=%b retired=%0d, want %0d 1 %0d",
                 i, pc, fetch, retired, exp_pc[i], i);
      end
      if (i == 4) halt = 1;
      tick();
    end
    halt = 0;
    n_vec++;
    if (done !== 1'b1 || fetch !== 1'b0 || pc !== 10'd1 || retired !== 16'd5) begin
      n_err++;
      $display("FAIL halt_done: done=%b fetch=%b pc=%0d retired=%0d, want 1 0 1 5",
               done, fetch, pc, retired);
    end
    // Decodes are ignored outside RUN.
    jump = 1; tgt_idx = 4'd3;
    tick();
    clear_decodes();
    n_vec++;
    if (pc !== 10'd1 || done !== 1'b1) begin
      n_err++;
      $display("FAIL done_hold: pc=%0d done=%b, want 1 1", pc, done);
    end
  endtask

  task automatic test_jump();
    apply_reset();
    write_lut(4'd3, 10'd200);
    write_lut(4'd5, 10'h3FC);
    write_lut(4'd6, 10'd300);
    write_lut(4'd7, 10'd50);
    write_lut(4'd8, 10'd2);
    start_addr = 10'd0; start = 1;
    tick();
    start = 0;
    tick();
    tick();
    n_vec++;
    if (pc !== 10'd2) begin
      n_err++;
      $display("FAIL jump_pre: pc=%0d, want 2", pc);
    end
    jump = 1; tgt_idx = 4'd3;
    tick();
    n_vec++;
    if (pc !== 10'd200) begin
      n_err++;
      $display("FAIL jump_abs: pc=%0d, want 200", pc);
    end
    jump = 1; branch_en = 1; zero = 1; tgt_idx = 4'd6;
    tick();
    clear_decodes();
    n_vec++;
    if (pc !== 10'd300) begin
      n_err++;
      $display("FAIL jump_over_branch: pc=%0d, want 300", pc);
    end
  endtask

  task automatic test_branch();
    jump = 1; tgt_idx = 4'd7;
    tick();
    jump = 0; branch_en = 1; zero = 0; tgt_idx = 4'd5;
    tick();
    n_vec++;
    if (pc !== 10'd51) begin
      n_err++;
      $display("FAIL branch_not_taken: pc=%0d, want 51", pc);
    end
    branch_en = 0; jump = 1; tgt_idx = 4'd7;
    tick();
    jump = 0; branch_en = 1; zero = 1; tgt_idx = 4'd5;
    tick();
    n_vec++;
    if (pc !== 10'd46) begin
      n_err++;
      $display("FAIL branch_taken: pc=%0d, want 46", pc);
    end
    branch_en = 0; zero = 0; jump = 1; tgt_idx = 4'd8;
    tick();
    jump = 0; branch_en = 1; zero = 1; tgt_idx = 4'd5;
    tick();
    clear_decodes();
    n_vec++;
    if (pc !== 10'd1022) begin
      n_err++;
      $display("FAIL branch_wrap: pc=%0d, want 1022", pc);
    end
  endtask

  task automatic test_handshake();
    lut_we = 1; lut_addr = 4'd5; lut_data = 10'd0;
    start = 1; start_addr = 10'd100;
    tick();
    lut_we = 0; start = 0;
    n_vec++;
    if (pc !== 10'd1023 || fetch !== 1'b1) begin
      n_err++;
      $display("FAIL start_in_run: pc=%0d fetch=%b, want 1023 1", pc, fetch);
    end
    branch_en = 1; zero = 1; tgt_idx = 4'd5;
    tick();
    clear_decodes();
    n_vec++;
    if (pc !== 10'd1019) begin
      n_err++;
      $display("FAIL lut_frozen: pc=%0d, want 1019", pc);
    end
    halt = 1;
    tick();
    halt = 0;
    n_vec++;
    if (done !== 1'b1 || pc !== 10'd1019) begin
      n_err++;
      $display("FAIL handshake_halt: done=%b pc=%0d, want 1 1019", done, pc);
    end
    start = 1; start_addr = 10'd7;
    tick();
    start = 0;
    n_vec++;
    if (pc !== 10'd7 || fetch !== 1'b1 || done !== 1'b0 || retired !== 16'd0) begin
      n_err++;
      $display("FAIL restart: pc=%0d fetch=%b done=%b retired=%0d, want 7 1 0 0",
               pc, fetch, done, retired);
    end
  endtask

  task automatic test_midrun_reset();
    apply_reset();
    write_lut(4'd3, 10'd200);
    start = 1; start_addr = 10'd37;
    tick();
    start = 0;
    n_vec++;
    if (pc !== 10'd37 || fetch !== 1'b1) begin
      n_err++;
      $display("FAIL midrun_pre: pc=%0d fetch=%b, want 37 1", pc, fetch);
    end
    reset_n = 1'b0;
    #2;
    n_vec++;
    if (pc !== 10'd0 || fetch !== 1'b0 || retired !== 16'd0) begin
      n_err++;
      $display("FAIL midrun_async_reset: pc=%0d fetch=%b retired=%0d, want 0 0 0",
               pc, fetch, retired);
    end
    reset_n = 1'b1;
    tick();
    // Start sampled on the first edge after release; LUT[3] must be cleared.
    start = 1; start_addr = 10'd9;
    tick();
    start = 0; jump = 1; tgt_idx = 4'd3;
    tick();
    clear_decodes();
    n_vec++;
    if (pc !== 10'd0) begin
      n_err++;
      $display("FAIL lut_cleared: pc=%0d, want 0", pc);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    start = 1; start_addr = 10'd0;
    tick();
    start = 0;
    for (int i = 0; i < 20; i++) begin
      n_vec++;
      if (sat_retired !== 4'((i > 15) ? 15 : i)) begin
        n_err++;
        $display("FAIL sat_count[%0d]: retired=%0d, want %0d", i, sat_retired,
                 (i > 15) ? 15 : i);
      end
      tick();
    end
    halt = 1;
    tick();
    halt = 0;
    n_vec++;
    if (sat_retired !== 4'd15 || sat_done !== 1'b1 || retired !== 16'd21) begin
      n_err++;
      $display("FAIL sat_final: sat_retired=%0d sat_done=%b retired=%0d, want 15 1 21",
               sat_retired, sat_done, retired);
    end
  endtask

  initial begin
    reset_n = 0; start = 0; start_addr = 0; lut_we = 0; lut_addr = 0; lut_data = 0;
    clear_decodes();
    #3;
    test_reset();
    test_seq_wrap();
    test_jump();
    test_branch();
    test_handshake();
    test_midrun_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
